// File: rtl/arb_memory.sv
// Multi-port arbitrated single-port memory.
// After reset the whole array is zeroed one word per cycle (CLEAR), then
// requests from NUM_PORTS channels are served round-robin, one access per
// cycle, with a registered one-cycle completion pulse per port.
module arb_memory #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int NUM_PORTS  = 2,
    parameter int BE_WIDTH   = WIDTH / 8
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NUM_PORTS-1:0]            valid_i,
    input  logic [NUM_PORTS-1:0]            wr_rd_i,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr_i,
    input  logic [NUM_PORTS*WIDTH-1:0]      wdata_i,
    input  logic [NUM_PORTS*BE_WIDTH-1:0]   be_i,
    output logic [NUM_PORTS*WIDTH-1:0]      rdata_o,
    output logic [NUM_PORTS-1:0]            ready_o,
    output logic [NUM_PORTS-1:0]            err_o,
    output logic                            init_done_o
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                     state_q, state_d;
    logic [ADDR_WIDTH-1:0]      clr_cnt_q, clr_cnt_d;
    logic [PW-1:0]              last_grant_q, last_grant_d;
    logic [NUM_PORTS-1:0]       ready_q, ready_d;
    logic [NUM_PORTS-1:0]       err_q, err_d;
    logic [NUM_PORTS*WIDTH-1:0] rdata_q;

    logic [WIDTH-1:0]           mem [DEPTH];

    // Per-port unpacked views of the packed request buses
    logic [ADDR_WIDTH-1:0]      port_addr  [NUM_PORTS];
    logic [WIDTH-1:0]           port_wdata [NUM_PORTS];
    logic [BE_WIDTH-1:0]        port_be    [NUM_PORTS];
    logic [NUM_PORTS-1:0]       in_range;
    logic [NUM_PORTS-1:0]       eligible;
    logic                       run_st;

    // Arbiter result and selected request
    logic                       gnt_valid;
    logic [PW-1:0]              gnt_idx;
    logic [ADDR_WIDTH-1:0]      sel_addr;
    logic [WIDTH-1:0]           sel_wdata;
    logic [BE_WIDTH-1:0]        sel_be;
    logic                       sel_wr;
    logic                       sel_in_range;

    // Memory port controls
    logic                       mem_we;
    logic [ADDR_WIDTH-1:0]      mem_waddr;
    logic [WIDTH-1:0]           mem_wdata;
    logic [BE_WIDTH-1:0]        mem_wbe;
    logic                       mem_re;

    assign run_st = (state_q == ST_RUN);

    // A port that just completed (ready high) is masked for one edge so a
    // held request is not served twice.
    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign port_addr[gi]  = addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign port_wdata[gi] = wdata_i[gi*WIDTH +: WIDTH];
            assign port_be[gi]    = be_i[gi*BE_WIDTH +: BE_WIDTH];
            assign in_range[gi]   = (port_addr[gi] <= ADDR_WIDTH'(DEPTH - 1));
            assign eligible[gi]   = valid_i[gi] & ~ready_q[gi] & run_st;
        end
    endgenerate

    // Round-robin search starting one past the last granted port
    always_comb begin
        int            cand;
        logic [PW-1:0] p;
        cand         = 0;
        p            = '0;
        gnt_valid    = 1'b0;
        gnt_idx      = '0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            cand = (int'(last_grant_q) + i) % NUM_PORTS;
            p    = PW'(cand);
            if (!gnt_valid && eligible[p]) begin
                gnt_valid = 1'b1;
                gnt_idx   = p;
            end
        end
        sel_addr     = port_addr[gnt_idx];
        sel_wdata    = port_wdata[gnt_idx];
        sel_be       = port_be[gnt_idx];
        sel_wr       = wr_rd_i[gnt_idx];
        sel_in_range = in_range[gnt_idx];
        ready_d      = '0;
        err_d        = '0;
        last_grant_d = last_grant_q;
        if (gnt_valid) begin
            ready_d[gnt_idx] = 1'b1;
            err_d[gnt_idx]   = ~sel_in_range;
            last_grant_d     = gnt_idx;
        end
    end

    // FSM state register and clear counter
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // FSM next state: sweep every address once, then run forever
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
                    state_d   = ST_RUN;
                    clr_cnt_d = '0;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // FSM outputs: memory port steering and init flag
    always_comb begin
        init_done_o = 1'b0;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        mem_waddr   = clr_cnt_q;
        mem_wdata   = '0;
        mem_wbe     = '1;
        case (state_q)
            ST_CLEAR: begin
                mem_we = 1'b1;
            end
            default: begin
                init_done_o = 1'b1;
                if (gnt_valid && sel_in_range) begin
                    if (sel_wr) begin
                        mem_we    = 1'b1;
                        mem_waddr = sel_addr;
                        mem_wdata = sel_wdata;
                        mem_wbe   = sel_be;
                    end else begin
                        mem_re = 1'b1;
                    end
                end
            end
        endcase
    end

    // Byte-masked array write; no reset so it maps onto block RAM
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < BE_WIDTH; b++) begin
                if (mem_wbe[b]) begin
                    mem[mem_waddr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Arbiter pointer and completion flags
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_grant_q <= PW'(NUM_PORTS - 1);
            ready_q      <= '0;
            err_q        <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            ready_q      <= ready_d;
            err_q        <= err_d;
        end
    end

    // Per-port read data, updated only when that port's read completes
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                if (ready_d[k] && !sel_wr) begin
                    rdata_q[k*WIDTH +: WIDTH] <= mem_re ? mem[sel_addr] : '0;
                end
            end
        end
    end

    assign ready_o = ready_q;
    assign err_o   = err_q;
    assign rdata_o = rdata_q;

endmodule

// File: tb/tb_arb_memory.sv
// Directed bench for arb_memory: clear timing, byte enables, round-robin,
// out-of-range handling, asynchronous reset and pending requests in CLEAR.
module tb_arb_memory;

    localparam int W  = 16;
    localparam int D  = 1000;
    localparam int AW = 10;
    localparam int NP = 2;
    localparam int BW = 2;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [NP-1:0]    valid_i;
    logic [NP-1:0]    wr_rd_i;
    logic [NP*AW-1:0] addr_i;
    logic [NP*W-1:0]  wdata_i;
    logic [NP*BW-1:0] be_i;
    logic [NP*W-1:0]  rdata_o;
    logic [NP-1:0]    ready_o;
    logic [NP-1:0]    err_o;
    logic             init_done_o;

    int passed = 0;
    int total  = 0;

    arb_memory #(
        .WIDTH     (W),
        .DEPTH     (D),
        .ADDR_WIDTH(AW),
        .NUM_PORTS (NP),
        .BE_WIDTH  (BW)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .valid_i    (valid_i),
        .wr_rd_i    (wr_rd_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .be_i       (be_i),
        .rdata_o    (rdata_o),
        .ready_o    (ready_o),
        .err_o      (err_o),
        .init_done_o(init_done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // One idle cycle, then issue a request and hold it until ready (bounded)
    task automatic do_req(input int port, input logic wr, input logic [AW-1:0] addr,
                          input logic [W-1:0] wdata, input logic [BW-1:0] be,
                          output int lat);
        tick();
        valid_i[port]          = 1'b1;
        wr_rd_i[port]          = wr;
        addr_i[port*AW +: AW]  = addr;
        wdata_i[port*W +: W]   = wdata;
        be_i[port*BW +: BW]    = be;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (ready_o[port] !== 1'b1 && lat < 50);
        valid_i[port] = 1'b0;
        $display("txn port=%0d wr=%0b addr=%0d wdata=%h be=%b ready=%b err=%b rdata=%h lat=%0d",
                 port, wr, addr, wdata, be, ready_o, err_o, rdata_o[port*W +: W], lat);
    endtask

    task automatic test_reset();
        int n;
        rst_i = 1'b1;
        #1;
        total++;
        if ({ready_o, err_o, init_done_o} !== 5'b0)
            $display("FAIL reset_flags: got %b expected 00000", {ready_o, err_o, init_done_o});
        else passed++;
        total++;
        if (rdata_o !== '0)
            $display("FAIL reset_rdata: got %h expected 0", rdata_o);
        else passed++;
        tick();
        tick();
        rst_i = 1'b0;
        n = 0;
        while (init_done_o !== 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        $display("txn clear cycles=%0d", n);
        total++;
        if (n != D)
            $display("FAIL clear_cycles: got %0d expected %0d", n, D);
        else passed++;
    endtask

    task automatic test_clear_reads();
        int lat;
        logic [AW-1:0] addrs [3];
        addrs[0] = 10'd0;
        addrs[1] = 10'd5;
        addrs[2] = 10'd999;
        for (int i = 0; i < 3; i++) begin
            do_req(i % 2, 1'b0, addrs[i], 16'h0, 2'b11, lat);
            total++;
            if (lat !== 1 || err_o[i%2] !== 1'b0 || rdata_o[(i%2)*W +: W] !== 16'h0)
                $display("FAIL clear_read_%0d: got lat=%0d err=%b rdata=%h expected lat=1 err=0 rdata=0000",
                         addrs[i], lat, err_o[i%2], rdata_o[(i%2)*W +: W]);
            else passed++;
        end
    endtask

    task automatic test_byte_enable();
        int lat;
        do_req(0, 1'b1, 10'd3, 16'hABCD, 2'b11, lat);
        total++;
        if (lat !== 1 || err_o[0] !== 1'b0)
            $display("FAIL be_wr_full: got lat=%0d err=%b expected lat=1 err=0", lat, err_o[0]);
        else passed++;
        do_req(0, 1'b1, 10'd3, 16'h1234, 2'b01, lat);
        total++;
        if (lat !== 1)
            $display("FAIL be_wr_low: got lat=%0d expected 1", lat);
        else passed++;
        do_req(0, 1'b0, 10'd3, 16'h0, 2'b00, lat);
        total++;
        if (rdata_o[15:0] !== 16'hAB34 || lat !== 1)
            $display("FAIL be_read: got rdata=%h lat=%0d expected rdata=ab34 lat=1", rdata_o[15:0], lat);
        else passed++;
        do_req(0, 1'b1, 10'd3, 16'hFFFF, 2'b00, lat);
        total++;
        if (lat !== 1 || ready_o !== 2'b01)
            $display("FAIL be_zero_ready: got lat=%0d ready=%b expected lat=1 ready=01", lat, ready_o);
        else passed++;
        do_req(0, 1'b0, 10'd3, 16'h0, 2'b11, lat);
        total++;
        if (rdata_o[15:0] !== 16'hAB34)
            $display("FAIL be_zero_nochange: got %h expected ab34", rdata_o[15:0]);
        else passed++;
    endtask

    task automatic test_round_robin();
        int lat;
        logic [NP-1:0] exp_rdy;
        do_req(0, 1'b1, 10'd10, 16'h1111, 2'b11, lat);
        do_req(1, 1'b1, 10'd20, 16'h2222, 2'b11, lat);
        tick();
        valid_i = 2'b11;
        wr_rd_i = 2'b00;
        addr_i  = {10'd20, 10'd10};
        for (int i = 0; i < 8; i++) begin
            tick();
            exp_rdy = (i % 2 == 0) ? 2'b01 : 2'b10;
            $display("txn rr cycle=%0d ready=%b rdata=%h", i, ready_o, rdata_o);
            total++;
            if (ready_o !== exp_rdy)
                $display("FAIL rr_ready_%0d: got %b expected %b", i, ready_o, exp_rdy);
            else passed++;
            total++;
            if ((i % 2 == 0 && rdata_o[15:0] !== 16'h1111) || (i % 2 == 1 && rdata_o[31:16] !== 16'h2222))
                $display("FAIL rr_rdata_%0d: got %h expected %h", i, rdata_o,
                         (i % 2 == 0) ? 16'h1111 : 16'h2222);
            else passed++;
        end
        valid_i = 2'b00;
    endtask

    task automatic test_out_of_range();
        int lat;
        do_req(1, 1'b1, 10'd1000, 16'hBEEF, 2'b11, lat);
        total++;
        if (lat !== 1 || err_o !== 2'b10 || rdata_o[31:16] !== 16'h2222)
            $display("FAIL oor_write: got lat=%0d err=%b rdata=%h expected lat=1 err=10 rdata=2222",
                     lat, err_o, rdata_o[31:16]);
        else passed++;
        tick();
        total++;
        if (err_o !== 2'b00 || ready_o !== 2'b00)
            $display("FAIL oor_err_clear: got err=%b ready=%b expected err=00 ready=00", err_o, ready_o);
        else passed++;
        do_req(1, 1'b0, 10'd1000, 16'h0, 2'b11, lat);
        total++;
        if (lat !== 1 || err_o[1] !== 1'b1 || rdata_o[31:16] !== 16'h0)
            $display("FAIL oor_read: got lat=%0d err=%b rdata=%h expected lat=1 err=1 rdata=0000",
                     lat, err_o[1], rdata_o[31:16]);
        else passed++;
        do_req(1, 1'b0, 10'd20, 16'h0, 2'b11, lat);
        total++;
        if (rdata_o[31:16] !== 16'h2222 || err_o[1] !== 1'b0)
            $display("FAIL oor_read20: got rdata=%h err=%b expected rdata=2222 err=0", rdata_o[31:16], err_o[1]);
        else passed++;
        do_req(1, 1'b0, 10'd999, 16'h0, 2'b11, lat);
        total++;
        if (rdata_o[31:16] !== 16'h0 || err_o[1] !== 1'b0)
            $display("FAIL oor_read999: got rdata=%h err=%b expected rdata=0000 err=0", rdata_o[31:16], err_o[1]);
        else passed++;
    endtask

    task automatic test_reset_mid_and_pending();
        int   n;
        logic early;
        tick();
        valid_i[0]   = 1'b1;
        wr_rd_i[0]   = 1'b1;
        addr_i[9:0]  = 10'd7;
        wdata_i[15:0] = 16'h7777;
        be_i[1:0]    = 2'b11;
        tick();
        total++;
        if (ready_o !== 2'b01)
            $display("FAIL rst_mid_grant: got %b expected 01", ready_o);
        else passed++;
        rst_i = 1'b1;
        #1;
        $display("txn async reset ready=%b err=%b rdata=%h init=%b", ready_o, err_o, rdata_o, init_done_o);
        total++;
        if ({ready_o, err_o, init_done_o} !== 5'b0 || rdata_o !== '0)
            $display("FAIL rst_mid_clear: got flags=%b rdata=%h expected flags=00000 rdata=0",
                     {ready_o, err_o, init_done_o}, rdata_o);
        else passed++;
        valid_i = 2'b00;
        tick();
        tick();
        rst_i = 1'b0;
        // Requests raised during CLEAR must wait, not be dropped
        valid_i = 2'b11;
        wr_rd_i = 2'b00;
        addr_i  = {10'd3, 10'd7};
        n = 0;
        early = 1'b0;
        while (init_done_o !== 1'b1 && n < 2000) begin
            tick();
            n++;
            if (ready_o !== 2'b00) early = 1'b1;
        end
        $display("txn restart clear cycles=%0d early_ready=%b", n, early);
        total++;
        if (n != D)
            $display("FAIL restart_cycles: got %0d expected %0d", n, D);
        else passed++;
        total++;
        if (early !== 1'b0)
            $display("FAIL clear_no_ready: got %b expected 0", early);
        else passed++;
        tick();
        total++;
        if (ready_o !== 2'b01 || rdata_o[15:0] !== 16'h0)
            $display("FAIL pend_port0: got ready=%b rdata=%h expected ready=01 rdata=0000", ready_o, rdata_o[15:0]);
        else passed++;
        valid_i[0] = 1'b0;
        tick();
        total++;
        if (ready_o !== 2'b10 || rdata_o[31:16] !== 16'h0)
            $display("FAIL pend_port1: got ready=%b rdata=%h expected ready=10 rdata=0000", ready_o, rdata_o[31:16]);
        else passed++;
        valid_i = 2'b00;
        tick();
    endtask

    initial begin
        rst_i   = 1'b1;
        valid_i = '0;
        wr_rd_i = '0;
        addr_i  = '0;
        wdata_i = '0;
        be_i    = '0;
        test_reset();
        test_clear_reads();
        test_byte_enable();
        test_round_robin();
        test_out_of_range();
        test_reset_mid_and_pending();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/arb_memory.md
ARB_MEMORY -- requirements
Module: arb_memory

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- WIDTH, 16, data word width in bits; multiple of 8.
- DEPTH, 1024, number of words; any value >= 2.
- ADDR_WIDTH, $clog2(DEPTH), address width.
- NUM_PORTS, 2, request channels; 1..4.
- BE_WIDTH, WIDTH/8, byte-enable width.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk_i, in, 1, single clock; all logic on its rising edge.
- rst_i, in, 1, reset; asynchronous, active-high.
- valid_i, in, NUM_PORTS, per-port request valid.
- wr_rd_i, in, NUM_PORTS, per-port operation: 1 = write, 0 = read.
- addr_i, in, NUM_PORTS*ADDR_WIDTH, packed per-port address; port k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- wdata_i, in, NUM_PORTS*WIDTH, packed per-port write data.
- be_i, in, NUM_PORTS*BE_WIDTH, packed per-port byte enables.
- rdata_o, out, NUM_PORTS*WIDTH, packed per-port read data; registered.
- ready_o, out, NUM_PORTS, per-port completion pulse; registered.
- err_o, out, NUM_PORTS, per-port out-of-range flag; valid only with ready_o.
- init_done_o, out, 1, high once the post-reset clear has finished.

Function
REQ-003 The block SHALL contain one DEPTH x WIDTH array with one access (read or write) per cycle.
REQ-004 The FSM SHALL have two states, CLEAR and RUN; reset SHALL enter CLEAR with clear counter = 0.
REQ-005 In CLEAR, the block SHALL write zero to the address given by the counter each cycle and increment the counter; after writing address DEPTH-1 it SHALL go to RUN on the next edge.
REQ-006 The CLEAR phase SHALL take exactly DEPTH cycles; init_done_o SHALL be 0 in CLEAR and 1 in RUN.
REQ-007 In CLEAR, no request SHALL be granted; all ready_o SHALL stay 0 and requests SHALL be held pending, not dropped.
REQ-008 In RUN, a port is eligible when valid_i[k]=1 and ready_o[k]=0; the ready_o term masks re-issue of a just-completed request.
REQ-009 Arbitration SHALL be round-robin:
- Search starts at (last_grant+1) mod NUM_PORTS.
- The first eligible port wins.
- last_grant resets to NUM_PORTS-1, so port 0 has first priority.
- last_grant updates only on a grant.
REQ-010 A port granted at edge t SHALL see ready_o[k]=1 for exactly one cycle after t; all other ready_o bits SHALL be 0 that cycle.
REQ-011 A requester SHALL hold valid/addr/data/be stable until it samples ready_o[k]=1; a new request presented in that ready cycle is eligible from the following edge.
REQ-012 A write SHALL update byte j of mem[addr] only where be[j]=1; be=0 SHALL complete with ready_o and no change to memory.
REQ-013 A read SHALL return mem[addr] on rdata_o[k] in the ready cycle, ignore be, and see all writes granted at earlier edges.
REQ-014 rdata_o[k] SHALL hold its value until port k's next read completes; writes SHALL not alter rdata_o.
REQ-015 addr >= DEPTH SHALL complete normally with ready_o=1 and err_o=1, no memory change, and rdata_o[k]=0 for reads.
REQ-016 err_o[k] SHALL be 0 in any cycle where ready_o[k]=0.
REQ-017 Simultaneous requests SHALL be served one per cycle, so sustained throughput is one access per cycle across all ports.

Reset
REQ-018 Asserting rst_i at any time, including mid-CLEAR or mid-transaction, SHALL immediately force:
- ready_o, err_o, rdata_o and init_done_o to 0;
- state to CLEAR;
- clear counter to 0;
- last_grant to NUM_PORTS-1.
REQ-019 An in-flight request SHALL be abandoned on reset; after deassertion a full DEPTH-cycle clear SHALL restart.

Verification
REQ-020 Reset, then ports idle: init_done_o rises exactly DEPTH cycles after rst_i falls, and reads of addresses 0, 5 and DEPTH-1 all return 0.
REQ-021 Port 0 writes 0xABCD to addr 3 with be=2'b11, then writes 0x1234 with be=2'b01; a read of addr 3 returns 0xAB34, with ready_o one cycle after each grant.
REQ-022 Both ports hold reads valid continuously after init: grants alternate 0,1,0,1; each ready_o[k] pulses every second cycle, never both high in the same cycle.
REQ-023 With DEPTH=1000, a port-1 write to addr 1000 gives ready_o[1]=1 and err_o[1]=1, a read of addr 1000 returns rdata 0 with err=1, and a read of addr 999 returns 0 with err=0.
REQ-024 A write to addr 7 is followed by rst_i asserted on the grant edge; all outputs clear asynchronously, the clear restarts, and addr 7 reads back 0 after init.
REQ-025 Requests raised during CLEAR receive no ready_o until init_done_o=1, then are served in round-robin order starting at port 0.
